// File: rtl/vga_fb_arbiter_if.sv
// Host write handshake plus single-port frame-buffer RAM bus.
interface vga_fb_arbiter_if;
  logic        wr_req;
  logic [14:0] wr_addr;
  logic [2:0]  wr_data;
  logic        wr_ack;
  logic        wr_err;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [2:0]  ram_wdata;
  logic [2:0]  ram_rdata;

  // Host and RAM environment side
  modport master (
    output wr_req, wr_addr, wr_data, ram_rdata,
    input  wr_ack, wr_err, ram_addr, ram_we, ram_wdata
  );

  // Arbiter side
  modport slave (
    input  wr_req, wr_addr, wr_data, ram_rdata,
    output wr_ack, wr_err, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer RAM arbiter: display fetches own the port on their slots,
// host writes fill the remaining cycles; 4x4 upscaled pixel scan-out.
module vga_fb_arbiter (
  input  logic            clk0,
  input  logic            reset,
  input  logic [9:0]      h_cnt,
  input  logic [9:0]      v_cnt,
  vga_fb_arbiter_if.slave bus,
  output logic            rgb_r,
  output logic            rgb_g,
  output logic            rgb_b
);
  localparam int unsigned H_ACT_START = 144;
  localparam int unsigned H_ACT_END   = 784;
  localparam int unsigned V_ACT_START = 34;
  localparam int unsigned V_ACT_END   = 514;
  localparam int unsigned FB_W        = 160;
  localparam int unsigned FB_H        = 120;
  localparam int unsigned FB_WORDS    = FB_W * FB_H;
  localparam int unsigned CW          = 10;
  localparam int unsigned AW          = 15;
  localparam int unsigned DW          = 3;
  localparam int unsigned COLW        = 8;
  localparam int unsigned ROWW        = 7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_data;
  logic            r_err;
  logic [DW-1:0]   r_pix;
  logic            r_slot_d;

  logic [CW-1:0]   w_h_off;
  logic [CW-1:0]   w_v_off;
  logic            w_h_fetch;
  logic            w_h_act;
  logic            w_v_act;
  logic            w_disp_slot;
  logic            w_pix_on;
  logic [COLW-1:0] w_col;
  logic [ROWW-1:0] w_row;
  logic [AW-1:0]   w_fetch_addr;

  logic            w_latch;
  logic            w_set_err;
  logic [AW-1:0]   w_ram_addr;
  logic            w_ram_we;
  logic [DW-1:0]   w_ram_wdata;

  // Fetch slot decode: every 4th cycle, 2 cycles ahead of the active window
  assign w_h_off     = h_cnt - CW'(H_ACT_START - 2);
  assign w_v_off     = v_cnt - CW'(V_ACT_START);
  assign w_h_fetch   = (h_cnt >= CW'(H_ACT_START - 2)) && (h_cnt < CW'(H_ACT_END - 2));
  assign w_h_act     = (h_cnt >= CW'(H_ACT_START)) && (h_cnt < CW'(H_ACT_END));
  assign w_v_act     = (v_cnt >= CW'(V_ACT_START)) && (v_cnt < CW'(V_ACT_END));
  assign w_disp_slot = w_h_fetch && w_v_act && (w_h_off[1:0] == 2'b00);

  // Linear fetch address row*160+col built from shifts
  assign w_col        = COLW'(w_h_off >> 2);
  assign w_row        = ROWW'(w_v_off >> 2);
  assign w_fetch_addr = (AW'(w_row) << 7) + (AW'(w_row) << 5) + AW'(w_col);

  // Host FSM next state and RAM port steering; display slot takes priority
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_set_err   = 1'b0;
    w_ram_addr  = '0;
    w_ram_we    = 1'b0;
    w_ram_wdata = '0;

    if (w_disp_slot) begin
      w_ram_addr = w_fetch_addr;
    end

    case (r_state)
      S_IDLE: begin
        if (bus.wr_req) begin
          w_latch     = 1'b1;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!w_disp_slot) begin
          if (r_addr < AW'(FB_WORDS)) begin
            w_ram_we    = 1'b1;
            w_ram_addr  = r_addr;
            w_ram_wdata = r_data;
          end else begin
            w_set_err = 1'b1;
          end
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Host FSM state register
  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latched host request and out-of-range flag
  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset) begin
      r_addr <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else if (w_latch) begin
      r_addr <= bus.wr_addr;
      r_data <= bus.wr_data;
      r_err  <= 1'b0;
    end else if (w_set_err) begin
      r_err  <= 1'b1;
    end
  end

  // Capture fetched word one cycle after its slot (synchronous RAM read)
  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset) begin
      r_slot_d <= 1'b0;
      r_pix    <= '0;
    end else begin
      r_slot_d <= w_disp_slot;
      if (r_slot_d) begin
        r_pix <= bus.ram_rdata;
      end
    end
  end

  assign bus.ram_addr  = w_ram_addr;
  assign bus.ram_we    = w_ram_we;
  assign bus.ram_wdata = w_ram_wdata;
  assign bus.wr_ack    = (r_state == S_DONE);
  assign bus.wr_err    = (r_state == S_DONE) && r_err;

  // Blank pixels outside the active window
  assign w_pix_on = w_h_act && w_v_act;
  assign rgb_r    = w_pix_on & r_pix[2];
  assign rgb_g    = w_pix_on & r_pix[1];
  assign rgb_b    = w_pix_on & r_pix[0];

  // Host writes must never share a cycle with a display fetch
  assert property (@(posedge clk0) disable iff (!reset) !(w_ram_we && w_disp_slot));

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural synchronous RAM.
module tb_vga_fb_arbiter;
  logic       clk0;
  logic       reset;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       rgb_r;
  logic       rgb_g;
  logic       rgb_b;
  logic [2:0] rgb;
  int         checks;
  int         errors;

  logic [2:0] mem [0:19199];

  vga_fb_arbiter_if bus ();

  vga_fb_arbiter dut (
    .clk0  (clk0),
    .reset (reset),
    .h_cnt (h_cnt),
    .v_cnt (v_cnt),
    .bus   (bus),
    .rgb_r (rgb_r),
    .rgb_g (rgb_g),
    .rgb_b (rgb_b)
  );

  assign rgb = {rgb_r, rgb_g, rgb_b};

  initial clk0 = 1'b0;
  always #20 clk0 = ~clk0;

  // Single-port RAM, read-before-write, 1-cycle read latency
  always @(posedge clk0) begin
    if (bus.ram_addr < 15'd19200) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_addr];
    end else begin
      bus.ram_rdata <= 3'b000;
    end
  end

  // Advance one clock, then apply new counters; outputs sampled 2 units after the edge
  task automatic step(input logic [9:0] h, input logic [9:0] v);
    @(posedge clk0);
    #1;
    h_cnt = h;
    v_cnt = v;
    #1;
  endtask

  // Plain host write during blanking (stimulus only)
  task automatic do_write(input logic [14:0] a, input logic [2:0] d);
    bus.wr_req  = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    step(10'd10, 10'd10);
    step(10'd10, 10'd10);
    bus.wr_req = 1'b0;
    step(10'd10, 10'd10);
  endtask

  task automatic test_reset;
    reset       = 1'b0;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 15'd300;
    bus.wr_data = 3'b110;
    h_cnt       = 10'd10;
    v_cnt       = 10'd10;
    for (int i = 0; i < 5; i++) begin
      step(10'd10, 10'd10);
      checks++;
      if ({bus.wr_ack, bus.ram_we, rgb} !== 5'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: ack/we/rgb=%b expected 00000", i, {bus.wr_ack, bus.ram_we, rgb});
      end
    end
    @(negedge clk0);
    reset = 1'b1;
    step(10'd10, 10'd10);
    checks++;
    if ({bus.ram_we, bus.ram_addr, bus.ram_wdata} !== {1'b1, 15'd300, 3'b110}) begin
      errors++;
      $display("FAIL reset_release_write: we=%b addr=%0d data=%b expected we=1 addr=300 data=110",
               bus.ram_we, bus.ram_addr, bus.ram_wdata);
    end
    step(10'd10, 10'd10);
    checks++;
    if ({bus.wr_ack, bus.wr_err} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release_ack: ack/err=%b expected 10", {bus.wr_ack, bus.wr_err});
    end
    bus.wr_req = 1'b0;
    step(10'd10, 10'd10);
    checks++;
    if ({bus.wr_ack, bus.ram_we, bus.ram_addr, bus.ram_wdata} !== 20'b0) begin
      errors++;
      $display("FAIL idle_port: ack=%b we=%b addr=%0d data=%b expected all 0",
               bus.wr_ack, bus.ram_we, bus.ram_addr, bus.ram_wdata);
    end
  endtask

  task automatic test_blank_write;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 15'd5;
    bus.wr_data = 3'b101;
    step(10'd10, 10'd10);
    checks++;
    if ({bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.wr_ack} !== {1'b1, 15'd5, 3'b101, 1'b0}) begin
      errors++;
      $display("FAIL blank_write_we: we=%b addr=%0d data=%b ack=%b expected 1 5 101 0",
               bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.wr_ack);
    end
    step(10'd10, 10'd10);
    checks++;
    if ({bus.wr_ack, bus.wr_err, bus.ram_we} !== 3'b100) begin
      errors++;
      $display("FAIL blank_write_ack: ack/err/we=%b expected 100", {bus.wr_ack, bus.wr_err, bus.ram_we});
    end
    checks++;
    if (mem[5] !== 3'b101) begin
      errors++;
      $display("FAIL blank_write_mem: mem[5]=%b expected 101", mem[5]);
    end
    bus.wr_req = 1'b0;
    step(10'd10, 10'd10);
  endtask

  task automatic test_back_to_back;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 15'd30;
    bus.wr_data = 3'b110;
    step(10'd10, 10'd10);
    step(10'd10, 10'd10);
    checks++;
    if (bus.wr_ack !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ack1: ack=%b expected 1", bus.wr_ack);
    end
    bus.wr_addr = 15'd31;
    bus.wr_data = 3'b001;
    step(10'd10, 10'd10);
    checks++;
    if ({bus.wr_ack, bus.ram_we} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_idle: ack/we=%b expected 00", {bus.wr_ack, bus.ram_we});
    end
    step(10'd10, 10'd10);
    checks++;
    if ({bus.ram_we, bus.ram_addr, bus.ram_wdata} !== {1'b1, 15'd31, 3'b001}) begin
      errors++;
      $display("FAIL b2b_we2: we=%b addr=%0d data=%b expected 1 31 001",
               bus.ram_we, bus.ram_addr, bus.ram_wdata);
    end
    step(10'd10, 10'd10);
    checks++;
    if (bus.wr_ack !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ack2: ack=%b expected 1", bus.wr_ack);
    end
    bus.wr_req = 1'b0;
    step(10'd10, 10'd10);
    checks++;
    if ({mem[30], mem[31]} !== 6'b110_001) begin
      errors++;
      $display("FAIL b2b_mem: mem[30]=%b mem[31]=%b expected 110 001", mem[30], mem[31]);
    end
  endtask

  task automatic test_out_of_range;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 15'd19200;
    bus.wr_data = 3'b111;
    step(10'd10, 10'd10);
    checks++;
    if ({bus.ram_we, bus.wr_ack} !== 2'b00) begin
      errors++;
      $display("FAIL oor_write: we/ack=%b expected 00", {bus.ram_we, bus.wr_ack});
    end
    step(10'd10, 10'd10);
    checks++;
    if ({bus.wr_ack, bus.wr_err, bus.ram_we} !== 3'b110) begin
      errors++;
      $display("FAIL oor_ack: ack/err/we=%b expected 110", {bus.wr_ack, bus.wr_err, bus.ram_we});
    end
    bus.wr_req = 1'b0;
    step(10'd10, 10'd10);
    checks++;
    if ({bus.wr_ack, bus.wr_err} !== 2'b00) begin
      errors++;
      $display("FAIL oor_clear: ack/err=%b expected 00", {bus.wr_ack, bus.wr_err});
    end
    // A following in-range write must not report an error
    bus.wr_req  = 1'b1;
    bus.wr_addr = 15'd19199;
    bus.wr_data = 3'b011;
    step(10'd10, 10'd10);
    step(10'd10, 10'd10);
    checks++;
    if ({bus.wr_ack, bus.wr_err} !== 2'b10) begin
      errors++;
      $display("FAIL last_addr_ack: ack/err=%b expected 10", {bus.wr_ack, bus.wr_err});
    end
    bus.wr_req = 1'b0;
    step(10'd10, 10'd10);
    checks++;
    if (mem[19199] !== 3'b011) begin
      errors++;
      $display("FAIL last_addr_mem: mem[19199]=%b expected 011", mem[19199]);
    end
  endtask

  task automatic test_scanout;
    logic [2:0] exp;
    for (int h = 140; h < 152; h++) begin
      step(10'(h), 10'd34);
      if (h >= 144) begin
        exp = (h < 148) ? 3'b100 : 3'b010;
        checks++;
        if (rgb !== exp) begin
          errors++;
          $display("FAIL scan_row0 h=%0d: rgb=%b expected %b", h, rgb, exp);
        end
      end
    end
    for (int h = 140; h <= 144; h++) begin
      step(10'(h), 10'd38);
      if (h == 142) begin
        checks++;
        if ({bus.ram_we, bus.ram_addr} !== {1'b0, 15'd160}) begin
          errors++;
          $display("FAIL scan_fetch_addr: we=%b addr=%0d expected 0 160", bus.ram_we, bus.ram_addr);
        end
      end
    end
    checks++;
    if (rgb !== 3'b001) begin
      errors++;
      $display("FAIL scan_row1: rgb=%b expected 001", rgb);
    end
    step(10'd784, 10'd34);
    checks++;
    if (rgb !== 3'b000) begin
      errors++;
      $display("FAIL scan_h_end: rgb=%b expected 000", rgb);
    end
    step(10'd150, 10'd514);
    checks++;
    if (rgb !== 3'b000) begin
      errors++;
      $display("FAIL scan_v_end: rgb=%b expected 000", rgb);
    end
    step(10'd10, 10'd10);
  endtask

  task automatic test_collision;
    step(10'd145, 10'd36);
    checks++;
    if ({bus.ram_we, bus.ram_addr} !== 16'b0) begin
      errors++;
      $display("FAIL coll_pre: we=%b addr=%0d expected 0 0", bus.ram_we, bus.ram_addr);
    end
    bus.wr_req  = 1'b1;
    bus.wr_addr = 15'd1000;
    bus.wr_data = 3'b011;
    step(10'd146, 10'd36);
    checks++;
    if ({bus.ram_we, bus.ram_addr, bus.wr_ack} !== {1'b0, 15'd1, 1'b0}) begin
      errors++;
      $display("FAIL coll_stall: we=%b addr=%0d ack=%b expected 0 1 0",
               bus.ram_we, bus.ram_addr, bus.wr_ack);
    end
    step(10'd147, 10'd36);
    checks++;
    if ({bus.ram_we, bus.ram_addr, bus.ram_wdata} !== {1'b1, 15'd1000, 3'b011}) begin
      errors++;
      $display("FAIL coll_write: we=%b addr=%0d data=%b expected 1 1000 011",
               bus.ram_we, bus.ram_addr, bus.ram_wdata);
    end
    step(10'd148, 10'd36);
    checks++;
    if ({bus.wr_ack, bus.ram_we} !== 2'b10) begin
      errors++;
      $display("FAIL coll_ack: ack/we=%b expected 10", {bus.wr_ack, bus.ram_we});
    end
    bus.wr_req = 1'b0;
    step(10'd10, 10'd10);
  endtask

  task automatic test_reset_during_write;
    step(10'd141, 10'd34);
    bus.wr_req  = 1'b1;
    bus.wr_addr = 15'd50;
    bus.wr_data = 3'b111;
    step(10'd142, 10'd34);
    checks++;
    if ({bus.ram_we, bus.ram_addr} !== 16'b0) begin
      errors++;
      $display("FAIL rst_mid_stall: we=%b addr=%0d expected 0 0", bus.ram_we, bus.ram_addr);
    end
    #5;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.ram_we, bus.wr_ack} !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_assert: we/ack=%b expected 00", {bus.ram_we, bus.wr_ack});
    end
    bus.wr_req = 1'b0;
    step(10'd10, 10'd10);
    @(negedge clk0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(10'd10, 10'd10);
      checks++;
      if ({bus.ram_we, bus.wr_ack} !== 2'b00) begin
        errors++;
        $display("FAIL rst_mid_after cyc%0d: we/ack=%b expected 00", i, {bus.ram_we, bus.wr_ack});
      end
    end
    checks++;
    if (mem[50] !== 3'b010) begin
      errors++;
      $display("FAIL rst_mid_mem: mem[50]=%b expected 010", mem[50]);
    end
    bus.wr_req  = 1'b1;
    bus.wr_addr = 15'd51;
    bus.wr_data = 3'b100;
    step(10'd10, 10'd10);
    checks++;
    if ({bus.ram_we, bus.ram_addr} !== {1'b1, 15'd51}) begin
      errors++;
      $display("FAIL rst_mid_idle: we=%b addr=%0d expected 1 51", bus.ram_we, bus.ram_addr);
    end
    step(10'd10, 10'd10);
    bus.wr_req = 1'b0;
    step(10'd10, 10'd10);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b0;
    h_cnt         = 10'd10;
    v_cnt         = 10'd10;
    bus.wr_req    = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.ram_rdata = '0;

    test_reset();
    test_blank_write();
    test_back_to_back();
    test_out_of_range();
    do_write(15'd0,   3'b100);
    do_write(15'd1,   3'b010);
    do_write(15'd160, 3'b001);
    do_write(15'd50,  3'b010);
    test_scanout();
    test_collision();
    test_reset_during_write();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
